// File: rtl/cordic_seq_ctrl_pkg.sv
// Shared types and constants for the CORDIC chain sequencer: widths, folded-angle
// thresholds (degrees scaled by 2^FRAC_BITS), FSM states and sign-magnitude helpers.
package cordic_seq_ctrl_pkg;

    localparam int DATA_WIDTH  = 20;
    localparam int PHI_WIDTH   = 22;
    localparam int FRAC_BITS   = 12;
    localparam int N_STAGES    = 14;
    localparam int TIMEOUT_CYC = 15;

    localparam logic [DATA_WIDTH-1:0] X0_INIT = DATA_WIDTH'(159188);

    localparam logic [PHI_WIDTH-1:0] ANG_90  = PHI_WIDTH'(90  << FRAC_BITS);
    localparam logic [PHI_WIDTH-1:0] ANG_180 = PHI_WIDTH'(180 << FRAC_BITS);
    localparam logic [PHI_WIDTH-1:0] ANG_270 = PHI_WIDTH'(270 << FRAC_BITS);
    localparam logic [PHI_WIDTH-1:0] ANG_360 = PHI_WIDTH'(360 << FRAC_BITS);

    typedef logic [DATA_WIDTH-1:0] sm_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_WAIT,
        ST_DONE
    } state_t;

    // A zero magnitude is always reported with a positive sign.
    function automatic sm_t sm_norm(input sm_t v);
        return (v[DATA_WIDTH-2:0] == '0) ? '0 : v;
    endfunction

    function automatic sm_t sm_neg(input sm_t v);
        return (v[DATA_WIDTH-2:0] == '0) ? '0 : {~v[DATA_WIDTH-1], v[DATA_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/cordic_seq_ctrl_if.sv
// Request/result handshake bundle between a client (master) and the sequencer (slave).
interface cordic_seq_ctrl_if
    import cordic_seq_ctrl_pkg::*;
();
    logic                  start_valid;
    logic                  start_ready;
    logic [PHI_WIDTH-1:0]  angle_in;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] cos_out;
    logic [DATA_WIDTH-1:0] sin_out;

    modport master (
        output start_valid, angle_in, res_ready,
        input  start_ready, res_valid, cos_out, sin_out
    );

    modport slave (
        input  start_valid, angle_in, res_ready,
        output start_ready, res_valid, cos_out, sin_out
    );
endinterface

// File: rtl/cordic_seq_ctrl_quad_fix.sv
// Combinational quarter fix-up: maps first-quadrant chain X/Y back to cos/sin of the
// full angle using sign-magnitude negation (MSB flip, never -0).
module cordic_seq_ctrl_quad_fix
    import cordic_seq_ctrl_pkg::*;
(
    input  logic [1:0] i_quarter,
    input  sm_t        i_x,
    input  sm_t        i_y,
    output sm_t        o_cos,
    output sm_t        o_sin
);
    always_comb begin
        o_cos = sm_norm(i_x);
        o_sin = sm_norm(i_y);
        case (i_quarter)
            2'd1: begin
                o_cos = sm_neg(i_y);
                o_sin = sm_norm(i_x);
            end
            2'd2: begin
                o_cos = sm_neg(i_x);
                o_sin = sm_neg(i_y);
            end
            2'd3: begin
                o_cos = sm_norm(i_y);
                o_sin = sm_neg(i_x);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/cordic_seq_ctrl.sv
// Sequences a one-hot enable wave through the CORDIC chain; result valid N_STAGES+2 edges after accept,
// held until res_ready. CORDIC_SEQ_TIMEOUT_EN adds a WAIT watchdog that ends the op with err=1.
module cordic_seq_ctrl
    import cordic_seq_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    cordic_seq_ctrl_if.slave      host,
    output logic                  stage_rst_step,
    output logic [N_STAGES-1:0]   stage_en,
    output logic [DATA_WIDTH-1:0] x0,
    output logic [DATA_WIDTH-1:0] y0,
    output logic [PHI_WIDTH-1:0]  phi0,
    output logic [1:0]            quarter,
    input  logic                  chain_done,
    input  logic [DATA_WIDTH-1:0] x_chain,
    input  logic [DATA_WIDTH-1:0] y_chain,
    output logic                  busy,
    output logic                  err
);
    localparam logic [3:0] STEP_LAST = 4'(N_STAGES - 1);

    state_t                r_state;
    logic [3:0]            r_step;
    logic [N_STAGES-1:0]   r_stage_en;
    logic                  r_rst_step;
    logic                  r_res_vld;
    sm_t                   r_cos;
    sm_t                   r_sin;
    logic [PHI_WIDTH-1:0]  r_phi0;
    logic [1:0]            r_quarter;

    logic [PHI_WIDTH-1:0]  w_ang;
    logic [PHI_WIDTH-1:0]  w_phi;
    logic [1:0]            w_quarter;
    sm_t                   w_cos;
    sm_t                   w_sin;

    // Fold [0,720) into [0,360), then split into quarter and a first-quadrant residual.
    always_comb begin
        w_ang = (host.angle_in >= ANG_360) ? host.angle_in - ANG_360 : host.angle_in;
        w_quarter = 2'd0;
        w_phi     = w_ang;
        if (w_ang >= ANG_270) begin
            w_quarter = 2'd3;
            w_phi     = w_ang - ANG_270;
        end else if (w_ang >= ANG_180) begin
            w_quarter = 2'd2;
            w_phi     = w_ang - ANG_180;
        end else if (w_ang >= ANG_90) begin
            w_quarter = 2'd1;
            w_phi     = w_ang - ANG_90;
        end
    end

    cordic_seq_ctrl_quad_fix u_quad_fix (
        .i_quarter (r_quarter),
        .i_x       (x_chain),
        .i_y       (y_chain),
        .o_cos     (w_cos),
        .o_sin     (w_sin)
    );

`ifdef CORDIC_SEQ_TIMEOUT_EN
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT_CYC - 1);
    logic [3:0] r_wait_cnt;
    logic       r_err;
    logic       w_timeout;

    assign w_timeout = (r_state == ST_WAIT) && !chain_done && (r_wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && host.start_valid) r_err <= 1'b0;
            else if (w_timeout)                         r_err <= 1'b1;
            r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 4'd1 : '0;
        end
    end

    assign err = r_err;
`else
    logic w_timeout;
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_step     <= '0;
            r_stage_en <= '0;
            r_rst_step <= 1'b0;
            r_res_vld  <= 1'b0;
            r_cos      <= '0;
            r_sin      <= '0;
            r_phi0     <= '0;
            r_quarter  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (host.start_valid) begin
                    r_phi0     <= w_phi;
                    r_quarter  <= w_quarter;
                    r_rst_step <= 1'b1;
                    r_state    <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    r_rst_step <= 1'b0;
                    r_stage_en <= N_STAGES'(1);
                    r_step     <= '0;
                    r_state    <= ST_RUN;
                end
                ST_RUN: if (r_step == STEP_LAST) begin
                    r_stage_en <= '0;
                    r_state    <= ST_WAIT;
                end else begin
                    r_stage_en <= r_stage_en << 1;
                    r_step     <= r_step + 4'd1;
                end
                ST_WAIT: if (chain_done) begin
                    r_cos     <= w_cos;
                    r_sin     <= w_sin;
                    r_res_vld <= 1'b1;
                    r_state   <= ST_DONE;
                end else if (w_timeout) begin
                    r_cos     <= '0;
                    r_sin     <= '0;
                    r_res_vld <= 1'b1;
                    r_state   <= ST_DONE;
                end
                ST_DONE: if (host.res_ready) begin
                    r_res_vld <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign host.start_ready = (r_state == ST_IDLE);
    assign host.res_valid   = r_res_vld;
    assign host.cos_out     = r_cos;
    assign host.sin_out     = r_sin;
    assign busy             = (r_state != ST_IDLE);
    assign stage_rst_step   = r_rst_step;
    assign stage_en         = r_stage_en;
    assign phi0             = r_phi0;
    assign quarter          = r_quarter;
    assign x0               = X0_INIT;
    assign y0               = '0;
endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed bench for cordic_seq_ctrl; a behavioural chain stand-in raises a sticky done after the last stage enable.
module tb_cordic_seq_ctrl;
    import cordic_seq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stage_rst_step, chain_done, busy, err, chain_dead;
    logic [N_STAGES-1:0]   stage_en;
    logic [DATA_WIDTH-1:0] x0, y0, x_chain, y_chain;
    logic [PHI_WIDTH-1:0]  phi0;
    logic [1:0]            quarter;
    int checks = 0;
    int errors = 0;

    cordic_seq_ctrl_if bus();

    cordic_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .host(bus),
        .stage_rst_step(stage_rst_step), .stage_en(stage_en),
        .x0(x0), .y0(y0), .phi0(phi0), .quarter(quarter),
        .chain_done(chain_done), .x_chain(x_chain), .y_chain(y_chain),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    chain_done <= 1'b0;
        else if (stage_rst_step)                       chain_done <= 1'b0;
        else if (stage_en[N_STAGES-1] && !chain_dead)  chain_done <= 1'b1;
    end

    // angle, x_chain, y_chain, quarter, phi0, cos, sin
    int tv [8][7] = '{
        '{0,       262150, 3,      0, 0,      262150, 3},
        '{368640,  262144, 0,      1, 0,      0,      262144},
        '{552960,  185364, 185364, 1, 184320, 709652, 185364},
        '{819200,  1000,   2000,   2, 81920,  525288, 526288},
        '{1228800, 7,      9,      3, 122880, 9,      524295},
        '{1474560, 100,    524288, 0, 0,      100,    0},
        '{2949119, 0,      524293, 3, 368639, 524293, 0},
        '{1105919, 3,      4,      2, 368639, 524291, 524292}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [PHI_WIDTH-1:0] ang, output int lat);
        bus.start_valid = 1'b1;
        bus.angle_in    = ang;
        tick();
        bus.start_valid = 1'b0;
        lat = 0;
        while (bus.res_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.start_valid = 1'b0; bus.angle_in = '0; bus.res_ready = 1'b0;
        x_chain = '0; y_chain = '0; chain_dead = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got %0b want 1", bus.start_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (stage_en !== '0 || stage_rst_step !== 1'b0) begin errors++; $display("FAIL reset_stage got en=%h rst_step=%b want 0/0", stage_en, stage_rst_step); end
        checks++; if (bus.res_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags got vld=%b err=%b want 0/0", bus.res_valid, err); end
        checks++; if (x0 !== 20'd159188 || y0 !== 20'd0) begin errors++; $display("FAIL reset_x0y0 got %0d/%0d want 159188/0", x0, y0); end
        checks++; if (phi0 !== '0 || quarter !== 2'd0) begin errors++; $display("FAIL reset_angle got phi0=%0d q=%0d want 0/0", phi0, quarter); end
        checks++; if (bus.cos_out !== '0 || bus.sin_out !== '0) begin errors++; $display("FAIL reset_cos_sin got %0d/%0d want 0/0", bus.cos_out, bus.sin_out); end
    endtask

    task automatic test_fold();
        int lat;
        for (int i = 0; i < 8; i++) begin
            x_chain = DATA_WIDTH'(tv[i][1]);
            y_chain = DATA_WIDTH'(tv[i][2]);
            launch(PHI_WIDTH'(tv[i][0]), lat);
            checks++; if (lat != N_STAGES + 2) begin errors++; $display("FAIL fold%0d_latency got %0d want %0d", i, lat, N_STAGES + 2); end
            checks++; if (quarter !== 2'(tv[i][3])) begin errors++; $display("FAIL fold%0d_quarter got %0d want %0d", i, quarter, tv[i][3]); end
            checks++; if (phi0 !== PHI_WIDTH'(tv[i][4])) begin errors++; $display("FAIL fold%0d_phi0 got %0d want %0d", i, phi0, tv[i][4]); end
            checks++; if (bus.cos_out !== DATA_WIDTH'(tv[i][5])) begin errors++; $display("FAIL fold%0d_cos got %0d want %0d", i, bus.cos_out, tv[i][5]); end
            checks++; if (bus.sin_out !== DATA_WIDTH'(tv[i][6])) begin errors++; $display("FAIL fold%0d_sin got %0d want %0d", i, bus.sin_out, tv[i][6]); end
            drain();
        end
    endtask

    task automatic test_wrap_walk();
        int n;
        logic [N_STAGES-1:0] exp_en;
        x_chain = 20'd1234; y_chain = 20'd567;
        bus.start_valid = 1'b1; bus.angle_in = 22'd1638400;
        tick();
        bus.start_valid = 1'b0;
        checks++; if (stage_rst_step !== 1'b1 || stage_en !== '0) begin errors++; $display("FAIL walk_clear got rst_step=%b en=%h want 1/0", stage_rst_step, stage_en); end
        checks++; if (quarter !== 2'd0 || phi0 !== 22'd163840) begin errors++; $display("FAIL walk_fold got q=%0d phi0=%0d want 0/163840", quarter, phi0); end
        for (int k = 0; k < N_STAGES; k++) begin
            tick();
            exp_en = N_STAGES'(1) << k;
            checks++; if (stage_en !== exp_en || stage_rst_step !== 1'b0) begin errors++; $display("FAIL walk_en%0d got en=%h rst_step=%b want %h/0", k, stage_en, stage_rst_step, exp_en); end
        end
        tick();
        checks++; if (stage_en !== '0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL walk_wait got en=%h vld=%b want 0/0", stage_en, bus.res_valid); end
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n != 1 || bus.cos_out !== 20'd1234 || bus.sin_out !== 20'd567) begin errors++; $display("FAIL walk_result got extra=%0d cos=%0d sin=%0d want 1/1234/567", n, bus.cos_out, bus.sin_out); end
        drain();
    endtask

    task automatic test_back_pressure();
        int lat;
        x_chain = 20'd100; y_chain = 20'd200;
        launch(22'd552960, lat);
        checks++; if (lat != N_STAGES + 2) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, N_STAGES + 2); end
        bus.start_valid = 1'b1; bus.angle_in = '0;
        x_chain = 20'd50; y_chain = 20'd60;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (bus.res_valid !== 1'b1 || bus.start_ready !== 1'b0 || bus.cos_out !== 20'd524488 || bus.sin_out !== 20'd100) begin errors++; $display("FAIL bp_hold%0d got vld=%b rdy=%b cos=%0d sin=%0d want 1/0/524488/100", c, bus.res_valid, bus.start_ready, bus.cos_out, bus.sin_out); end
        end
        bus.res_ready = 1'b1;
        tick();
        checks++; if (bus.res_valid !== 1'b0 || bus.start_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_drain got vld=%b rdy=%b busy=%b want 0/1/0", bus.res_valid, bus.start_ready, busy); end
        tick();
        bus.start_valid = 1'b0;
        checks++; if (busy !== 1'b1 || stage_rst_step !== 1'b1 || quarter !== 2'd0) begin errors++; $display("FAIL bp_accept got busy=%b rst_step=%b q=%0d want 1/1/0", busy, stage_rst_step, quarter); end
        lat = 0;
        while (bus.res_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        checks++; if (lat != N_STAGES + 2 || bus.cos_out !== 20'd50 || bus.sin_out !== 20'd60) begin errors++; $display("FAIL bp_next got lat=%0d cos=%0d sin=%0d want 16/50/60", lat, bus.cos_out, bus.sin_out); end
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        x_chain = 20'd11; y_chain = 20'd22;
        bus.start_valid = 1'b1; bus.angle_in = '0;
        tick();
        bus.start_valid = 1'b0;
        repeat (4) tick();
        checks++; if (stage_en !== 14'h0008) begin errors++; $display("FAIL mid_run3 got en=%h want 0008", stage_en); end
        rst_n = 1'b0;
        #1;
        checks++; if (stage_en !== '0 || busy !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL mid_abort got en=%h busy=%b vld=%b want 0/0/0", stage_en, busy, bus.res_valid); end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (bus.start_ready !== 1'b1 || stage_en !== '0 || phi0 !== '0) begin errors++; $display("FAIL mid_idle got rdy=%b en=%h phi0=%0d want 1/0/0", bus.start_ready, stage_en, phi0); end
        launch(22'd552960, lat);
        checks++; if (lat != N_STAGES + 2 || bus.cos_out !== 20'd524310 || bus.sin_out !== 20'd11) begin errors++; $display("FAIL mid_recover got lat=%0d cos=%0d sin=%0d want 16/524310/11", lat, bus.cos_out, bus.sin_out); end
        drain();
    endtask

    task automatic test_dead_chain();
        int lat;
        x_chain = 20'd5; y_chain = 20'd6;
        chain_dead = 1'b1;
        launch('0, lat);
`ifdef CORDIC_SEQ_TIMEOUT_EN
        checks++; if (lat != N_STAGES + 1 + TIMEOUT_CYC) begin errors++; $display("FAIL timeout_latency got %0d want %0d", lat, N_STAGES + 1 + TIMEOUT_CYC); end
        checks++; if (err !== 1'b1 || bus.cos_out !== '0 || bus.sin_out !== '0) begin errors++; $display("FAIL timeout_result got err=%b cos=%0d sin=%0d want 1/0/0", err, bus.cos_out, bus.sin_out); end
        drain();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err_held got %b want 1", err); end
        chain_dead = 1'b0;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear got %b want 0", err); end
        lat = 0;
        while (bus.res_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        checks++; if (bus.cos_out !== 20'd5 || err !== 1'b0) begin errors++; $display("FAIL timeout_recover got cos=%0d err=%b want 5/0", bus.cos_out, err); end
        drain();
`else
        checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL dead_wait got vld=%b busy=%b err=%b want 0/1/0", bus.res_valid, busy, err); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chain_dead = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || bus.start_ready !== 1'b1) begin errors++; $display("FAIL dead_recover got busy=%b rdy=%b want 0/1", busy, bus.start_ready); end
`endif
    endtask

    initial begin
        test_reset();
        test_fold();
        test_wrap_walk();
        test_back_pressure();
        test_reset_mid_run();
        test_dead_chain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish before 200000");
        $fatal(1, "bench time limit");
    end
endmodule
